btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL sit directly upstream of the button counter and provide a clean press pulse for its btnIn input.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the consecutive stable synchronized samples needed to accept a level change (legal range >= 1).
REQ-003 Parameter REPEAT_DELAY, default 50000000, SHALL set the number of HELD cycles before the first auto-repeat pulse (legal range >= 1).
REQ-004 Parameter REPEAT_PERIOD, default 10000000, SHALL set the number of cycles between later auto-repeat pulses (legal range >= 1).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 btnIn  input  1  raw asynchronous bouncing button level, active-high.
REQ-008 btnLevel  output  1  debounced button level.
REQ-009 btnPulse  output  1  one-cycle strobe per accepted press, plus auto-repeats when enabled.
REQ-010 btnRelease  output  1  one-cycle strobe per accepted release.

Function
REQ-011 btnIn SHALL pass through a 2-flop synchronizer; the FSM SHALL observe only the second flop (btnSync).
REQ-012 The FSM SHALL have four states: IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-013 IDLE: if btnSync=1, go to PRESS_WAIT with debounce counter = 0; otherwise stay.
REQ-014 PRESS_WAIT: if btnSync=0, return to IDLE (bounce rejected, no output).
REQ-015 PRESS_WAIT: if btnSync=1 and counter = DEBOUNCE_CYCLES-1, go to HELD; otherwise increment the counter.
REQ-016 RELEASE_WAIT SHALL mirror PRESS_WAIT with btnSync polarity inverted and targets HELD (on bounce) and IDLE (on acceptance).
REQ-017 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, SHALL be cleared on every state change and SHALL never wrap.
REQ-018 btnLevel SHALL be 1 exactly when the state is HELD or RELEASE_WAIT.
REQ-019 btnPulse SHALL be 1 for exactly the first cycle after a PRESS_WAIT->HELD transition; a RELEASE_WAIT->HELD return SHALL NOT pulse.
REQ-020 btnRelease SHALL be 1 for exactly the first cycle after a RELEASE_WAIT->IDLE transition.
REQ-021 Latency: if btnIn is first sampled 1 at edge E and held stable, btnPulse SHALL be 1 in the cycle after edge E+DEBOUNCE_CYCLES+2; release latency is identical.
REQ-022 All outputs SHALL be registered, with no combinational path from btnIn.

Reset
REQ-023 While rst=1 at a clock edge, synchronizer flops, state (IDLE), all counters, btnLevel, btnPulse and btnRelease SHALL all become 0.
REQ-024 Reset asserted mid-debounce or in HELD SHALL abort the operation with no pulse emitted; no btnRelease SHALL be generated by reset.
REQ-025 A button held through reset release SHALL require a full debounce and then give exactly one btnPulse, DEBOUNCE_CYCLES+3 cycles after the last edge with rst=1.

Configuration
REQ-026 Macro BTN_DEBOUNCE_REPEAT_EN SHALL gate the auto-repeat feature.
REQ-027 With the macro defined, a repeat counter SHALL be cleared whenever the state is not HELD.
REQ-028 With the macro defined, btnPulse SHALL also assert at HELD cycle index REPEAT_DELAY, then every REPEAT_PERIOD cycles while HELD (HELD entry cycle = index 0).
REQ-029 The auto-repeat timer SHALL not overflow or change cadence for any hold length.
REQ-030 Without the macro, btnPulse SHALL occur only per REQ-019, and the repeat parameters SHALL be accepted but unused, with no repeat logic synthesized.

Verification
(All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.)
REQ-031 Clean press: btnIn 0->1 sampled at edge E, held 20 cycles -> single btnPulse in the cycle after E+6; btnLevel=1 from then on; btnRelease stays 0.
REQ-032 Bounce and glitch: btnIn high 2 cycles, low 1, high 2, low 1, then held high -> no pulse during the bounce; exactly one btnPulse 6 edges after the final rising sample.
REQ-033 Release: from HELD, btnIn 1->0 at edge F and held -> btnRelease one cycle after F+6 and btnLevel=0; a 2-cycle low glitch instead -> no btnRelease and btnLevel stays 1.
REQ-034 Reset mid-operation: rst high 1 cycle during PRESS_WAIT, btnIn kept high -> all outputs 0 during reset; exactly one btnPulse 7 cycles after the rst edge.
REQ-035 Repeat, macro defined: hold btnIn 30 cycles -> btnPulse at HELD indices 0, 8, 11, 14, 17, ...; macro undefined -> only index 0.
REQ-036 Downstream: btnPulse drives the counter's btnIn; 3 clean presses -> counter advances by exactly 3.

Source files
------------

// File: rtl/btn_debounce.sv
// btn_debounce: push-button conditioner placed directly in front of the
// button counter. The raw button passes through a two-flop synchronizer.
// A four-state FSM then debounces both edges of the button. It produces
// a registered level, a one-cycle press strobe and a one-cycle release
// strobe.
//
// Optional feature: define BTN_DEBOUNCE_REPEAT_EN to enable auto-repeat.
// With auto-repeat, btnPulse fires again after REPEAT_DELAY held cycles.
// It then fires every REPEAT_PERIOD cycles for as long as the button
// stays held. Without the macro, the repeat parameters are only range
// checked and no repeat hardware exists.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btnIn,
    output logic btnLevel,
    output logic btnPulse,
    output logic btnRelease
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state, next_state;
    logic          btnMeta, btnSync;
    logic [CW-1:0] cnt, next_cnt;
    logic          press_accept, release_accept;
    logic          repeat_hit;

    // Two-flop synchronizer; only btnSync is visible to the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            btnMeta <= 1'b0;
            btnSync <= 1'b0;
        end else begin
            btnMeta <= btnIn;
            btnSync <= btnMeta;
        end
    end

    // State and debounce counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic. The counter restarts at every state change and
    // stops at CNT_LAST, so it can never wrap.
    always_comb begin
        next_state     = state;
        next_cnt       = cnt;
        press_accept   = 1'b0;
        release_accept = 1'b0;
        case (state)
            IDLE: begin
                if (btnSync) begin
                    next_state = PRESS_WAIT;
                    next_cnt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btnSync) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state   = HELD;
                    next_cnt     = '0;
                    press_accept = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btnSync) begin
                    next_state = RELEASE_WAIT;
                    next_cnt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btnSync) begin
                    next_state = HELD;
                    next_cnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state     = IDLE;
                    next_cnt       = '0;
                    release_accept = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    // rcnt holds the HELD cycle index, where the entry cycle is index 0.
    // Once it reaches REPEAT_DELAY, it circulates between REPEAT_DELAY and
    // REPEAT_DELAY+REPEAT_PERIOD-1. The cadence therefore never changes,
    // and the counter never overflows, however long the button is held.
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_inc;
    logic          stay_held;

    assign rcnt_inc   = rcnt + 1'b1;
    assign stay_held  = (state == HELD) && (next_state == HELD);
    assign repeat_hit = stay_held && ((rcnt_inc == RPT_FIRST) || (rcnt_inc == RPT_WRAP));

    // Repeat timer: cleared outside HELD, advances once per held cycle.
    always_ff @(posedge clk) begin
        if (rst || !stay_held) begin
            rcnt <= '0;
        end else if (rcnt_inc == RPT_WRAP) begin
            rcnt <= RPT_FIRST;
        end else begin
            rcnt <= rcnt_inc;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    // Registered outputs. They are derived from the next state, so each
    // strobe appears in the first cycle of the new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            btnLevel   <= 1'b0;
            btnPulse   <= 1'b0;
            btnRelease <= 1'b0;
        end else begin
            btnLevel   <= (next_state == HELD) || (next_state == RELEASE_WAIT);
            btnPulse   <= press_accept | repeat_hit;
            btnRelease <= release_accept;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios plus a randomized phase. Every cycle
// is checked against a run-length model of the debouncer, with D=4, RD=8
// and RP=3. Define BTN_DEBOUNCE_REPEAT_EN to build the auto-repeat
// variant.
module tb_btn_debounce;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnIn = 1'b0;
    logic btnLevel, btnPulse, btnRelease;

    btn_debounce #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btnIn     (btnIn),
        .btnLevel  (btnLevel),
        .btnPulse  (btnPulse),
        .btnRelease(btnRelease)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: the two delay slots of the synchronizer, the
    // accepted level, the run length of samples that disagree with that
    // level, and the index of the current uninterrupted held stretch.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0;
    int   m_run = 0, m_idx = 0;
    bit   m_held = 1'b0;
    logic e_level = 1'b0, e_pulse = 1'b0, e_rel = 1'b0;

    int ecount = 0;
    int pcnt = 0, rcnt = 0, first_p = -1, first_r = -1, down_cnt = 0;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic s;
        bit   prev;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0;
            m_run = 0; m_idx = 0; m_held = 1'b0;
            e_level = 1'b0; e_pulse = 1'b0; e_rel = 1'b0;
        end else begin
            s = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            e_pulse = 1'b0;
            e_rel = 1'b0;
            prev = m_held;
            if (s != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl = s;
                    m_run = 0;
                    e_pulse = s;
                    e_rel = ~s;
                end
            end else begin
                m_run = 0;
            end
            m_held = m_lvl && (m_run == 0);
            m_idx = (m_held && prev) ? m_idx + 1 : 0;
            if (RPT && m_held && prev && m_idx >= RD && ((m_idx - RD) % RP) == 0)
                e_pulse = 1'b1;
            e_level = m_lvl;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare
    // on the falling edge.
    task automatic tick(input logic b, input logic r);
        btnIn = b;
        rst = r;
        @(posedge clk);
        ecount++;
        model_edge(b, r);
        @(negedge clk);
        chk1("level", btnLevel, e_level);
        chk1("pulse", btnPulse, e_pulse);
        chk1("release", btnRelease, e_rel);
        if (btnPulse === 1'b1) begin
            pcnt++;
            down_cnt++;
            if (first_p < 0) first_p = ecount;
        end
        if (btnRelease === 1'b1) begin
            rcnt++;
            if (first_r < 0) first_r = ecount;
        end
    endtask

    task automatic clr_stats();
        pcnt = 0; rcnt = 0; first_p = -1; first_r = -1;
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) tick(b, 1'b0);
    endtask

    initial begin
        int e0, er;
        logic cur;
        int left;

        @(negedge clk);
        // Reset state
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        chk1("reset_level", btnLevel, 1'b0);
        chk1("reset_pulse", btnPulse, 1'b0);
        chk1("reset_release", btnRelease, 1'b0);
        hold(1'b0, 4);

        // Clean press held 20 cycles
        clr_stats();
        e0 = ecount + 1;
        hold(1'b1, 20);
        chkn("press_count", pcnt, RPT ? 3 : 1);
        chkn("press_edge", first_p, e0 + 6);
        chkn("press_norel", rcnt, 0);
        chk1("press_level", btnLevel, 1'b1);

        // Clean release
        clr_stats();
        e0 = ecount + 1;
        hold(1'b0, 12);
        chkn("rel_count", rcnt, 1);
        chkn("rel_edge", first_r, e0 + 6);
        chk1("rel_level", btnLevel, 1'b0);

        // Bounce then a stable press
        clr_stats();
        hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 1);
        chkn("bounce_nopulse", pcnt, 0);
        e0 = ecount + 1;
        hold(1'b1, 12);
        chkn("bounce_count", pcnt, 1);
        chkn("bounce_edge", first_p, e0 + 6);

        // Short low glitch while held
        clr_stats();
        hold(1'b0, 2);
        hold(1'b1, 10);
        chkn("glitch_norel", rcnt, 0);
        chk1("glitch_level", btnLevel, 1'b1);
        hold(1'b0, 12);

        // Reset during PRESS_WAIT with the button kept high
        clr_stats();
        hold(1'b1, 3);
        tick(1'b1, 1'b1);
        er = ecount;
        chk1("midrst_level", btnLevel, 1'b0);
        chk1("midrst_pulse", btnPulse, 1'b0);
        chk1("midrst_release", btnRelease, 1'b0);
        hold(1'b1, 12);
        chkn("midrst_count", pcnt, 1);
        chkn("midrst_edge", first_p, er + 7);
        chkn("midrst_norel", rcnt, 0);
        hold(1'b0, 12);

        // Downstream counter: three clean presses
        down_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            hold(1'b1, 8);
            hold(1'b0, 12);
        end
        chkn("downstream_count", down_cnt, 3);

        // Long hold (auto-repeat cadence when enabled)
        clr_stats();
        hold(1'b1, 30);
        chkn("repeat_count", pcnt, RPT ? 7 : 1);
        hold(1'b0, 12);

        // Randomized bursts with occasional reset
        left = 0;
        cur = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (left == 0) begin
                cur = 1'($urandom_range(0, 1));
                left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 30))
                                                  : int'($urandom_range(1, 9));
            end
            left--;
            tick(cur, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
